// File: rtl/hack_pkg.sv
// Shared definitions for the Hack CPU controller: FSM states, IR field
// positions, destination/jump encodings and the instruction decode helper.
package hack_pkg;

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    READ   = 3'd2,
    EXEC   = 3'd3,
    WRITE  = 3'd4
  } state_e;

  // Instruction field positions (16-bit Hack word)
  localparam int unsigned CI_BIT  = 15;
  localparam int unsigned A_BIT   = 12;
  localparam int unsigned CTRL_HI = 11;
  localparam int unsigned CTRL_LO = 6;
  localparam int unsigned DEST_HI = 5;
  localparam int unsigned DEST_LO = 3;
  localparam int unsigned JUMP_HI = 2;
  localparam int unsigned JUMP_LO = 0;

  // Destination bit positions within the DEST field
  localparam int unsigned DST_A = 2;
  localparam int unsigned DST_D = 1;
  localparam int unsigned DST_M = 0;

  // Jump encodings
  localparam logic [2:0] JNULL = 3'b000;
  localparam logic [2:0] JGT   = 3'b001;
  localparam logic [2:0] JEQ   = 3'b010;
  localparam logic [2:0] JGE   = 3'b011;
  localparam logic [2:0] JLT   = 3'b100;
  localparam logic [2:0] JNE   = 3'b101;
  localparam logic [2:0] JLE   = 3'b110;
  localparam logic [2:0] JMP   = 3'b111;

  // Decoded instruction register; bits 14:13 of a C-instruction carry no meaning
  typedef struct packed {
    logic       c;
    logic       a;
    logic [5:0] ctrl;
    logic [2:0] dest;
    logic [2:0] jump;
  } ir_t;

  function automatic ir_t decode_ir(input logic [15:0] w);
    ir_t r;
    r.c    = w[CI_BIT];
    r.a    = w[A_BIT];
    r.ctrl = w[CTRL_HI:CTRL_LO];
    r.dest = w[DEST_HI:DEST_LO];
    r.jump = w[JUMP_HI:JUMP_LO];
    return r;
  endfunction

endpackage

// File: rtl/hack_jump_cond.sv
// Resolves a Hack jump field against the ALU zero/negative flags.
module hack_jump_cond
  import hack_pkg::*;
(
  input  logic [2:0] jump,
  input  logic       zr,
  input  logic       ng,
  output logic       take
);

  // Less-than, equal and greater-than are mutually exclusive; each jump bit enables one
  always_comb begin
    take = (jump[2] & ng) | (jump[1] & zr) | (jump[0] & ~ng & ~zr);
  end

endmodule

// File: rtl/hack_cpu_ctrl.sv
// Multi-cycle Hack CPU control/datapath: owns A, D, PC, drives the external
// ALU, fetches from a synchronous ROM and accesses data memory via req/ack.
module hack_cpu_ctrl
  import hack_pkg::*;
#(
  parameter int unsigned        ADDR_W   = 15,
  parameter int unsigned        DATA_W   = 16,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] pc,
  input  logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] alu_x,
  output logic [DATA_W-1:0] alu_y,
  output logic              za,
  output logic              na,
  output logic              zb,
  output logic              nb,
  output logic              f,
  output logic              no,
  input  logic [DATA_W-1:0] alu_out,
  input  logic              zr,
  input  logic              ng,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              retire
);

  state_e            state_q;
  logic [ADDR_W-1:0] pc_q;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] d_q;
  ir_t               ir_q;
  logic [DATA_W-1:0] mdr_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] res_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic              retire_q;

  logic [ADDR_W-1:0] pc_inc;
  logic              take;
  ir_t               dec;

  hack_jump_cond u_jump (
    .jump (ir_q.jump),
    .zr   (zr),
    .ng   (ng),
    .take (take)
  );

  // Next sequential PC (wraps at 2^ADDR_W) and decode of the incoming ROM word
  always_comb begin
    pc_inc = pc_q + 1'b1;
    dec    = decode_ir(instr);
  end

  // Main FSM: all architectural registers and handshake outputs update here
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= FETCH;
      pc_q      <= RESET_PC;
      a_q       <= '0;
      d_q       <= '0;
      ir_q      <= '0;
      mdr_q     <= '0;
      addr_q    <= '0;
      res_q     <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      retire_q  <= 1'b0;
    end else begin
      retire_q <= 1'b0;
      unique case (state_q)
        FETCH: state_q <= DECODE;
        DECODE: begin
          ir_q <= dec;
          if (!dec.c) begin
            a_q      <= instr;
            pc_q     <= pc_inc;
            retire_q <= 1'b1;
            state_q  <= FETCH;
          end else begin
            // Latch the M address now so a same-instruction A update cannot move it
            addr_q <= a_q[ADDR_W-1:0];
            if (dec.a) begin
              mem_req_q <= 1'b1;
              mem_we_q  <= 1'b0;
              state_q   <= READ;
            end else begin
              state_q <= EXEC;
            end
          end
        end
        READ: begin
          if (mem_ack) begin
            mdr_q     <= mem_rdata;
            mem_req_q <= 1'b0;
            state_q   <= EXEC;
          end
        end
        EXEC: begin
          res_q <= alu_out;
          if (ir_q.dest[DST_A]) a_q <= alu_out;
          if (ir_q.dest[DST_D]) d_q <= alu_out;
          // a_q here is still the pre-instruction value on this edge
          pc_q <= take ? a_q[ADDR_W-1:0] : pc_inc;
          if (ir_q.dest[DST_M]) begin
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= WRITE;
          end else begin
            retire_q <= 1'b1;
            state_q  <= FETCH;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            retire_q  <= 1'b1;
            state_q   <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // Output mapping from registered state
  always_comb begin
    pc        = pc_q;
    alu_x     = d_q;
    alu_y     = ir_q.a ? mdr_q : a_q;
    {za, na, zb, nb, f, no} = ir_q.c ? ir_q.ctrl : 6'b0;
    mem_req   = mem_req_q;
    mem_we    = mem_we_q;
    mem_addr  = addr_q;
    mem_wdata = res_q;
    retire    = retire_q;
  end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Directed bench for hack_cpu_ctrl: ROM, data memory with programmable wait
// and a Hack ALU model surround the DUT; short programs are run per vector.
module tb_hack_cpu_ctrl;
  import hack_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [14:0] pc;
  logic [15:0] instr = '0;
  logic [15:0] alu_x, alu_y, alu_out;
  logic        za, na, zb, nb, f, no, zr, ng;
  logic        mem_req, mem_we, mem_ack, retire;
  logic [14:0] mem_addr;
  logic [15:0] mem_wdata, mem_rdata;

  always #5 clk = ~clk;

  hack_cpu_ctrl #(.ADDR_W(15), .DATA_W(16), .RESET_PC(15'd0)) dut (
    .clk(clk), .rst_n(rst_n), .pc(pc), .instr(instr),
    .alu_x(alu_x), .alu_y(alu_y),
    .za(za), .na(na), .zb(zb), .nb(nb), .f(f), .no(no),
    .alu_out(alu_out), .zr(zr), .ng(ng),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .retire(retire)
  );

  // Hack ALU model
  logic [15:0] ax, ay, ao;
  always_comb begin
    ax = za ? 16'h0 : alu_x;
    if (na) ax = ~ax;
    ay = zb ? 16'h0 : alu_y;
    if (nb) ay = ~ay;
    ao = f ? (ax + ay) : (ax & ay);
    if (no) ao = ~ao;
    alu_out = ao;
    zr = (ao == 16'h0);
    ng = ao[15];
  end

  // Synchronous instruction ROM
  logic [15:0] rom [0:32767];
  always @(posedge clk) instr <= rom[pc];

  // Data memory: ack after wait_cycles extra cycles of request, one word at cur_maddr
  int unsigned wait_cycles = 0;
  logic [14:0] cur_maddr = '0;
  logic [15:0] cur_mval = '0;
  int unsigned wcnt_q = 0;
  always_comb begin
    mem_ack   = mem_req && (wcnt_q == wait_cycles);
    mem_rdata = (mem_addr == cur_maddr) ? cur_mval : 16'hDEAD;
  end
  always @(posedge clk) begin
    if (mem_req && !mem_ack) wcnt_q <= wcnt_q + 1;
    else                     wcnt_q <= 0;
  end

  // Transaction monitor (cumulative counters)
  int unsigned wr_n = 0, rd_n = 0, req_n = 0;
  logic [14:0] last_waddr = '0, last_raddr = '0;
  logic [15:0] last_wdata = '0;
  always @(posedge clk) begin
    if (mem_req) req_n <= req_n + 1;
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wr_n <= wr_n + 1;
        last_waddr <= mem_addr;
        last_wdata <= mem_wdata;
      end else begin
        rd_n <= rd_n + 1;
        last_raddr <= mem_addr;
      end
    end
  end

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic [15:0] i0, i1, i2, i3, itop;
    int unsigned nret;
    int unsigned wt;
    logic [15:0] mval;
    logic [14:0] exp_pc;
    logic [15:0] exp_a, exp_d;
    int unsigned exp_cyc, exp_rd, exp_wr;
    logic [14:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t vecs [10];

  initial begin
    int unsigned cyc, ret, wr0, rd0, rq0, n;
    string tag;

    //          i0       i1       i2       i3  itop     nret wt mval    pc        a         d         cyc rd wr addr     wdata
    vecs[0] = '{16'h0005, 16'h0000, 16'h0000, 0, 16'h0000, 1, 0, 16'd0, 15'd1,    16'd5,    16'd0,    2,  0, 0, 15'd0,   16'd0};
    vecs[1] = '{16'h0005, 16'hEDD0, 16'h0000, 0, 16'h0000, 2, 0, 16'd0, 15'd2,    16'd5,    16'd6,    5,  0, 0, 15'd0,   16'd0};
    vecs[2] = '{16'h0064, 16'hFC90, 16'h0000, 0, 16'h0000, 2, 3, 16'd7, 15'd2,    16'd100,  16'd6,    9,  1, 0, 15'd100, 16'd0};
    vecs[3] = '{16'h0064, 16'hEFD0, 16'hE7E8, 0, 16'h0000, 3, 0, 16'd0, 15'd3,    16'd2,    16'd1,    9,  0, 1, 15'd100, 16'd2};
    vecs[4] = '{16'h0014, 16'hEA90, 16'hE302, 0, 16'h0000, 3, 0, 16'd0, 15'd20,   16'd20,   16'd0,    8,  0, 0, 15'd0,   16'd0};
    vecs[5] = '{16'h0014, 16'hEE90, 16'hE301, 0, 16'h0000, 3, 0, 16'd0, 15'd3,    16'd20,   16'hFFFF, 8,  0, 0, 15'd0,   16'd0};
    vecs[6] = '{16'h0014, 16'hEE90, 16'hE304, 0, 16'h0000, 3, 0, 16'd0, 15'd20,   16'd20,   16'hFFFF, 8,  0, 0, 15'd0,   16'd0};
    vecs[7] = '{16'h0064, 16'hEFD0, 16'hE7FF, 0, 16'h0000, 3, 1, 16'd0, 15'd100,  16'd2,    16'd2,    10, 0, 1, 15'd100, 16'd2};
    vecs[8] = '{16'h7FFF, 16'hEA87, 16'h0000, 0, 16'hEFD0, 3, 0, 16'd0, 15'd0,    16'h7FFF, 16'd1,    8,  0, 0, 15'd0,   16'd0};
    vecs[9] = '{16'h0064, 16'hFDC8, 16'h0000, 0, 16'h0000, 2, 2, 16'd7, 15'd2,    16'd100,  16'd0,    11, 1, 1, 15'd100, 16'd8};

    for (int i = 0; i < 32768; i++) rom[i] = 16'h0000;

    // Reset state, observed while reset is held
    #3;
    chk("rst_pc", 32'(pc), 32'd0);
    chk("rst_mem_req", 32'(mem_req), 32'd0);
    chk("rst_retire", 32'(retire), 32'd0);
    chk("rst_aluctl", 32'({za, na, zb, nb, f, no}), 32'd0);
    chk("rst_alu_x", 32'(alu_x), 32'd0);
    chk("rst_state", 32'(dut.state_q), 32'(FETCH));

    foreach (vecs[v]) begin
      rom[0] = vecs[v].i0; rom[1] = vecs[v].i1; rom[2] = vecs[v].i2; rom[3] = vecs[v].i3;
      rom[32767] = vecs[v].itop;
      wait_cycles = vecs[v].wt;
      cur_maddr = vecs[v].exp_addr;
      cur_mval = vecs[v].mval;
      do_reset();
      wr0 = wr_n; rd0 = rd_n; rq0 = req_n;
      cyc = 0; ret = 0;
      while (ret < vecs[v].nret && cyc < 200) begin
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (retire) ret++;
      end
      tag = $sformatf("v%0d", v);
      chk({tag, "_retires"}, ret, vecs[v].nret);
      chk({tag, "_cycles"}, cyc, vecs[v].exp_cyc);
      chk({tag, "_pc"}, 32'(pc), 32'(vecs[v].exp_pc));
      chk({tag, "_A"}, 32'(dut.a_q), 32'(vecs[v].exp_a));
      chk({tag, "_D"}, 32'(alu_x), 32'(vecs[v].exp_d));
      chk({tag, "_reads"}, rd_n - rd0, vecs[v].exp_rd);
      chk({tag, "_writes"}, wr_n - wr0, vecs[v].exp_wr);
      chk({tag, "_req_cycles"}, req_n - rq0, (vecs[v].exp_rd + vecs[v].exp_wr) * (vecs[v].wt + 1));
      if (vecs[v].exp_rd != 0) chk({tag, "_raddr"}, 32'(last_raddr), 32'(vecs[v].exp_addr));
      if (vecs[v].exp_wr != 0) begin
        chk({tag, "_waddr"}, 32'(last_waddr), 32'(vecs[v].exp_addr));
        chk({tag, "_wdata"}, 32'(last_wdata), 32'(vecs[v].exp_wdata));
      end
      @(negedge clk);
      chk({tag, "_retire_pulse"}, 32'(retire), 32'd0);
    end

    // Reset asserted mid-read: request must drop immediately
    rom[0] = 16'h0064; rom[1] = 16'hFC10; rom[2] = 16'h0000; rom[32767] = 16'h0000;
    wait_cycles = 1000;
    cur_maddr = 15'd100;
    do_reset();
    n = 0;
    while (!mem_req && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("t6_req_seen", 32'(mem_req), 32'd1);
    chk("t6_req_addr", 32'(mem_addr), 32'd100);
    chk("t6_req_we", 32'(mem_we), 32'd0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_req_drop", 32'(mem_req), 32'd0);
    chk("t6_retire", 32'(retire), 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    wait_cycles = 0;
    chk("t6_pc", 32'(pc), 32'd0);
    chk("t6_state", 32'(dut.state_q), 32'(FETCH));
    chk("t6_A", 32'(dut.a_q), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
